// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and moves instructions from the single-port
// instruction memory into IF/ID, handling stalls, redirects and halt.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, WAIT, HALT} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic        buf_valid;
    logic [15:0] buf_instr;
    logic [15:0] buf_addr;
    logic        drop;

    logic        fetch_issue;
    logic        deliver;
    logic [15:0] dlv_instr;
    logic [15:0] dlv_addr;

    // Once a request is outstanding (WAIT) it must stay up on the latched address.
    assign fetch_issue = (state == FETCH) & ~stall & ~buf_valid & ~branch_taken;
    assign imem_req    = rst_n & (fetch_issue | (state == WAIT));
    assign imem_addr   = (state == WAIT) ? req_addr : pc;
    assign flush_ifid  = rst_n & branch_taken;

    always_comb begin
        deliver   = 1'b0;
        dlv_instr = imem_data;
        dlv_addr  = imem_addr;
        if (!branch_taken) begin
            case (state)
                FETCH: begin
                    if (buf_valid && !stall) begin
                        deliver   = 1'b1;
                        dlv_instr = buf_instr;
                        dlv_addr  = buf_addr;
                    end else if (fetch_issue && imem_rdy) begin
                        deliver = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rdy && !drop && !stall) begin
                        deliver = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            buf_valid   <= 1'b0;
            buf_instr   <= 16'h0000;
            buf_addr    <= 16'h0000;
            drop        <= 1'b0;
            if_instr    <= 16'h0000;
            if_pc_plus2 <= 16'h0000;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (state == FETCH) begin
                req_addr <= pc;
            end
            if (branch_taken) begin
                pc        <= branch_target;
                if_valid  <= 1'b0;
                buf_valid <= 1'b0;
                case (state)
                    WAIT: begin
                        // Data still in flight belongs to the wrong path.
                        if (imem_rdy) begin
                            state <= FETCH;
                            drop  <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    HALT: begin
                        state  <= FETCH;
                        halted <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end else if (deliver) begin
                if_instr    <= dlv_instr;
                if_pc_plus2 <= dlv_addr + 16'd2;
                if_valid    <= 1'b1;
                buf_valid   <= 1'b0;
                if (dlv_instr[15:12] == HALT_OPCODE) begin
                    pc     <= dlv_addr;
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    pc    <= dlv_addr + 16'd2;
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (!stall) begin
                            if_valid <= 1'b0;
                        end
                        if (fetch_issue) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!stall) begin
                            if_valid <= 1'b0;
                        end
                        if (imem_rdy) begin
                            state <= FETCH;
                            if (drop) begin
                                drop <= 1'b0;
                            end else begin
                                buf_valid <= 1'b1;
                                buf_instr <= imem_data;
                                buf_addr  <= req_addr;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: request/response model of the fetch
// path compared every cycle, plus hand-computed directed expectations.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        flush_ifid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic        auto_rdy = 1'b1;
    int          lat      = 0;
    int          wait_cnt = 0;
    logic        last_req = 1'b0;
    logic        last_rdy = 1'b0;
    logic        last_rst = 1'b0;
    logic [15:0] halt_at  = 16'hFFFF;

    // Model: pc, an outstanding request (possibly dead), a held word, IF/ID view.
    logic        model_ready = 1'b0;
    logic [15:0] m_pc = 16'h0;
    logic        m_out = 1'b0;
    logic [15:0] m_out_addr = 16'h0;
    logic        m_out_dead = 1'b0;
    logic        m_held = 1'b0;
    logic [15:0] m_held_word = 16'h0;
    logic [15:0] m_held_addr = 16'h0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = 16'h0;
    logic [15:0] m_plus2 = 16'h0;
    logic        m_halted = 1'b0;

    fetch_sequencer #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_rdy     (imem_rdy),
        .imem_data    (imem_data),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .if_instr     (if_instr),
        .if_pc_plus2  (if_pc_plus2),
        .if_valid     (if_valid),
        .flush_ifid   (flush_ifid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == halt_at) ? 16'hF000 : (16'h1000 | a);
    endfunction

    function automatic logic model_req();
        if (!rst_n)
            return 1'b0;
        if (m_out)
            return 1'b1;
        if (m_halted)
            return 1'b0;
        return !stall && !m_held && !branch_taken;
    endfunction

    function automatic logic [15:0] model_addr();
        return m_out ? m_out_addr : m_pc;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs on the falling edge; the memory answers after settling.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [15:0] t, input logic rd);
        @(negedge clk);
        if (!last_rst)
            wait_cnt = 0;
        else if (last_req && last_rdy)
            wait_cnt = 0;
        else if (last_req)
            wait_cnt++;
        rst_n         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
        imem_rdy  = imem_req && (auto_rdy ? (wait_cnt >= lat) : rd);
        imem_data = mem_word(imem_addr);
        last_req  = imem_req;
        last_rdy  = imem_rdy;
        last_rst  = r;
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0050, 1'b0);
    endtask

    always @(posedge clk) begin
        logic        req, got, dlv;
        logic [15:0] a, w, da;
        req = model_req();
        a   = model_addr();
        got = req && imem_rdy;
        dlv = 1'b0;
        w   = 16'h0;
        da  = 16'h0;
        if (!rst_n) begin
            model_ready = 1'b1;
            m_pc = 16'h0000; m_out = 1'b0; m_out_dead = 1'b0; m_held = 1'b0;
            m_valid = 1'b0; m_instr = 16'h0; m_plus2 = 16'h0; m_halted = 1'b0;
        end else begin
            if (branch_taken) begin
                m_pc = branch_target; m_valid = 1'b0; m_held = 1'b0; m_halted = 1'b0;
            end else if (!m_halted) begin
                if (m_held && !stall) begin
                    dlv = 1'b1; w = m_held_word; da = m_held_addr; m_held = 1'b0;
                end else if (got && !m_out_dead) begin
                    if (stall) begin
                        m_held = 1'b1; m_held_word = mem_word(a); m_held_addr = a;
                    end else begin
                        dlv = 1'b1; w = mem_word(a); da = a;
                    end
                end
                if (dlv) begin
                    m_valid = 1'b1; m_instr = w; m_plus2 = da + 16'd2;
                    if (w[15:12] == 4'hF) begin
                        m_pc = da; m_halted = 1'b1;
                    end else begin
                        m_pc = da + 16'd2;
                    end
                end else if (!stall) begin
                    m_valid = 1'b0;
                end
            end
            if (got) begin
                m_out = 1'b0; m_out_dead = 1'b0;
            end else if (req) begin
                m_out = 1'b1; m_out_addr = a;
                if (branch_taken) m_out_dead = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (model_ready) begin
            checkOutput("imem_req", 16'(imem_req), 16'(model_req()));
            if (model_req())
                checkOutput("imem_addr", imem_addr, model_addr());
            checkOutput("flush_ifid", 16'(flush_ifid), 16'(rst_n & branch_taken));
            checkOutput("if_valid", 16'(if_valid), 16'(m_valid));
            if (m_valid) begin
                checkOutput("if_instr", if_instr, m_instr);
                checkOutput("if_pc_plus2", if_pc_plus2, m_plus2);
            end
            checkOutput("halted", 16'(halted), 16'(m_halted));
        end
    end

    initial begin
        logic [15:0] exp_a;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_rdy = 1'b0; imem_data = 16'h0;

        $display("[TB] back-to-back fetch");
        auto_rdy = 1'b1; lat = 0;
        doReset();
        checkOutput("reset imem_req", 16'(imem_req), 16'h0);
        checkOutput("reset flush_ifid", 16'(flush_ifid), 16'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            exp_a = 16'(2 * i);
            checkOutput("A imem_addr", imem_addr, exp_a);
            if (i == 0) begin
                checkOutput("A if_valid0", 16'(if_valid), 16'h0);
                checkOutput("A if_instr0", if_instr, 16'h0000);
            end else begin
                checkOutput("A if_pc_plus2", if_pc_plus2, exp_a);
                checkOutput("A if_instr", if_instr, 16'h1000 | (exp_a - 16'd2));
            end
        end

        $display("[TB] slow memory");
        lat = 3;
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            checkOutput("B held imem_addr", imem_addr, 16'h0000);
            checkOutput("B held imem_req", 16'(imem_req), 16'h1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("B if_valid", 16'(if_valid), 16'h1);
        checkOutput("B if_pc_plus2", if_pc_plus2, 16'h0002);
        checkOutput("B next addr", imem_addr, 16'h0002);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("B bubble", 16'(if_valid), 16'h0);
        runCycles(10);

        $display("[TB] stall during wait");
        auto_rdy = 1'b0;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        checkOutput("C req in stall", 16'(imem_req), 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        checkOutput("C req in stall2", 16'(imem_req), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("C req on release", 16'(imem_req), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("C buffered instr", if_instr, 16'h1000);
        checkOutput("C buffered valid", 16'(if_valid), 16'h1);
        checkOutput("C next addr", imem_addr, 16'h0002);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("C second instr", if_instr, 16'h1002);
        checkOutput("C second plus2", if_pc_plus2, 16'h0004);

        $display("[TB] redirect during wait");
        auto_rdy = 1'b1; lat = 0;
        doReset();
        runCycles(5);
        auto_rdy = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("D wait addr", imem_addr, 16'h000A);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
        checkOutput("D flush", 16'(flush_ifid), 16'h1);
        checkOutput("D addr held", imem_addr, 16'h000A);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("D flush once", 16'(flush_ifid), 16'h0);
        checkOutput("D killed valid", 16'(if_valid), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("D stale addr", imem_addr, 16'h000A);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("D target addr", imem_addr, 16'h0040);
        checkOutput("D discarded", 16'(if_valid), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("D target instr", if_instr, 16'h1040);
        checkOutput("D target plus2", if_pc_plus2, 16'h0042);

        $display("[TB] reset mid-wait");
        auto_rdy = 1'b1; lat = 3;
        doReset();
        runCycles(6);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0);
        checkOutput("F reset req", 16'(imem_req), 16'h0);
        checkOutput("F reset flush", 16'(flush_ifid), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("F if_valid", 16'(if_valid), 16'h0);
        checkOutput("F if_instr", if_instr, 16'h0000);
        checkOutput("F if_pc_plus2", if_pc_plus2, 16'h0000);
        checkOutput("F restart addr", imem_addr, 16'h0000);
        runCycles(4);
        checkOutput("F first instr", if_instr, 16'h1000);

        $display("[TB] halt and resume");
        auto_rdy = 1'b1; lat = 0; halt_at = 16'h0010;
        doReset();
        runCycles(9);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("E halt instr", if_instr, 16'hF000);
        checkOutput("E halted", 16'(halted), 16'h1);
        checkOutput("E no req", 16'(imem_req), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("E still no req", 16'(imem_req), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 1'b1);
        checkOutput("E exit flush", 16'(flush_ifid), 16'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("E unhalted", 16'(halted), 16'h0);
        checkOutput("E resume addr", imem_addr, 16'h0020);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("E resume instr", if_instr, 16'h1020);

        $display("[TB] mixed stall/redirect/memory pattern");
        auto_rdy = 1'b0; halt_at = 16'h0030;
        doReset();
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'b1, ($urandom % 4) == 0, ($urandom % 8) == 0,
                          16'($urandom_range(0, 40)) << 1, ($urandom % 2) == 1);
        end
        runCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
